vmem_fill_engine: RTL and testbench



---
 rtl/vmem_fill_engine_pkg.sv | 33 +++
 rtl/vmem_fill_scan.sv | 53 +++++
 rtl/vmem_fill_engine.sv | 173 +++++++++++++++++
 tb/tb_vmem_fill_engine.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_fill_engine_pkg.sv
// Shared constants for the vmem rectangle-fill engine: display geometry,
// register map, CTRL bit positions and FSM encoding.
package vmem_fill_engine_pkg;

    localparam int DEF_DISP_W  = 240;
    localparam int DEF_DISP_H  = 240;
    localparam int DEF_COLOR_W = 3;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_ORIGIN = 3'd1;
    localparam logic [2:0] REG_SIZE   = 3'd2;
    localparam logic [2:0] REG_COLOR  = 3'd3;
    localparam logic [2:0] REG_PIXCNT = 3'd4;

    localparam int CTRL_START    = 0;
    localparam int CTRL_ABORT    = 1;
    localparam int CTRL_CLR_DONE = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2
    } fill_state_e;

    // Exclusive end coordinate, clipped to the display edge (10-bit so x0+w cannot wrap).
    function automatic logic [9:0] clip_end(input logic [7:0] org, input logic [8:0] len,
                                            input logic [9:0] lim);
        logic [9:0] sum;
        sum = {2'b00, org} + {1'b0, len};
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

// File: rtl/vmem_fill_scan.sv
// Row-major x/y raster counter over [x0,x_end) x [y0,y_end); holds while not enabled.
module vmem_fill_scan
    import vmem_fill_engine_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic       i_en,
    input  logic [7:0] i_x0,
    input  logic [7:0] i_y0,
    input  logic [9:0] i_x_end,
    input  logic [9:0] i_y_end,
    output logic [7:0] o_cx,
    output logic [7:0] o_cy,
    output logic       o_last
);

    logic [7:0] r_x0;
    logic [7:0] r_cx;
    logic [7:0] r_cy;
    logic [9:0] r_x_end;
    logic [9:0] r_y_end;
    logic       w_x_wrap;

    assign w_x_wrap = (({2'b00, r_cx} + 10'd1) == r_x_end);
    assign o_last   = w_x_wrap && (({2'b00, r_cy} + 10'd1) == r_y_end);
    assign o_cx     = r_cx;
    assign o_cy     = r_cy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x0    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_x_end <= '0;
            r_y_end <= '0;
        end else if (i_load) begin
            r_x0    <= i_x0;
            r_cx    <= i_x0;
            r_cy    <= i_y0;
            r_x_end <= i_x_end;
            r_y_end <= i_y_end;
        end else if (i_en) begin
            if (w_x_wrap) begin
                r_cx <= r_x0;
                r_cy <= r_cy + 8'd1;
            end else begin
                r_cx <= r_cx + 8'd1;
            end
        end
    end

endmodule

// File: rtl/vmem_fill_engine.sv
// Rectangle-fill engine and vmem write-port arbiter; CPU direct writes always win.
// state | meaning
// IDLE  | waiting for start
// SETUP | clip bounds, latch working copies, reject empty boxes
// RUN   | one pixel per non-stalled cycle
module vmem_fill_engine
    import vmem_fill_engine_pkg::*;
#(
    parameter int DISP_W  = DEF_DISP_W,
    parameter int DISP_H  = DEF_DISP_H,
    parameter int COLOR_W = DEF_COLOR_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               reg_we_i,
    input  logic [4:0]         reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic [31:0]        reg_rdata_o,
    input  logic               cpu_we_i,
    input  logic [15:0]        cpu_waddr_i,
    input  logic [COLOR_W-1:0] cpu_wdata_i,
    output logic               vmem_we_o,
    output logic [15:0]        vmem_waddr_o,
    output logic [COLOR_W-1:0] vmem_wdata_o,
    output logic               busy_o
);

    fill_state_e        r_state;
    logic [7:0]         r_x0;
    logic [7:0]         r_y0;
    logic [8:0]         r_w;
    logic [8:0]         r_h;
    logic [COLOR_W-1:0] r_color;
    logic [COLOR_W-1:0] r_fill_color;
    logic [16:0]        r_pixcnt;
    logic               r_done;

    logic               w_ctrl_wr;
    logic               w_start;
    logic               w_abort;
    logic               w_clr_done;
    logic               w_busy;
    logic               w_empty;
    logic               w_scan_en;
    logic               w_scan_last;
    logic [9:0]         w_x_end;
    logic [9:0]         w_y_end;
    logic [7:0]         w_cx;
    logic [7:0]         w_cy;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_ctrl_wr  = reg_we_i && (reg_addr_i[4:2] == REG_CTRL);
    assign w_start    = w_ctrl_wr && reg_wdata_i[CTRL_START];
    assign w_abort    = w_ctrl_wr && reg_wdata_i[CTRL_ABORT];
    assign w_clr_done = w_ctrl_wr && reg_wdata_i[CTRL_CLR_DONE];
    assign w_busy     = (r_state != ST_IDLE);
    assign busy_o     = w_busy;
    assign w_unused   = ^{reg_addr_i[1:0], reg_wdata_i[31:25]};

    assign w_x_end = clip_end(r_x0, r_w, 10'(DISP_W));
    assign w_y_end = clip_end(r_y0, r_h, 10'(DISP_H));
    assign w_empty = (r_w == 9'd0) || (r_h == 9'd0) ||
                     ({2'b00, r_x0} >= 10'(DISP_W)) || ({2'b00, r_y0} >= 10'(DISP_H));
    assign w_scan_en = (r_state == ST_RUN) && !cpu_we_i && !w_abort;

    vmem_fill_scan u_scan (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_load  (r_state == ST_SETUP),
        .i_en    (w_scan_en),
        .i_x0    (r_x0),
        .i_y0    (r_y0),
        .i_x_end (w_x_end),
        .i_y_end (w_y_end),
        .o_cx    (w_cx),
        .o_cy    (w_cy),
        .o_last  (w_scan_last)
    );

    always_comb begin
        w_rdata = '0;
        case (reg_addr_i[4:2])
            REG_CTRL:   w_rdata[1:0] = {r_done, w_busy};
            REG_ORIGIN: w_rdata[15:0] = {r_y0, r_x0};
            REG_SIZE: begin
                w_rdata[24:16] = r_h;
                w_rdata[8:0]   = r_w;
            end
            REG_COLOR:  w_rdata[COLOR_W-1:0] = r_color;
            REG_PIXCNT: w_rdata[16:0] = r_pixcnt;
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_x0         <= '0;
            r_y0         <= '0;
            r_w          <= '0;
            r_h          <= '0;
            r_color      <= '0;
            r_fill_color <= '0;
            r_pixcnt     <= '0;
            r_done       <= 1'b0;
            vmem_we_o    <= 1'b0;
            vmem_waddr_o <= '0;
            vmem_wdata_o <= '0;
            reg_rdata_o  <= '0;
        end else begin
            reg_rdata_o <= w_rdata;
            if (reg_we_i) begin
                case (reg_addr_i[4:2])
                    REG_ORIGIN: {r_y0, r_x0} <= reg_wdata_i[15:0];
                    REG_SIZE: begin
                        r_w <= reg_wdata_i[8:0];
                        r_h <= reg_wdata_i[24:16];
                    end
                    REG_COLOR: r_color <= reg_wdata_i[COLOR_W-1:0];
                    default: ;
                endcase
            end

            // CPU owns the write port this cycle; the engine branch below stalls.
            vmem_we_o <= 1'b0;
            if (cpu_we_i) begin
                vmem_we_o    <= 1'b1;
                vmem_waddr_o <= cpu_waddr_i;
                vmem_wdata_o <= cpu_wdata_i;
            end

            if (w_clr_done) r_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_start && !w_abort) begin
                        r_state  <= ST_SETUP;
                        r_done   <= 1'b0;
                        r_pixcnt <= '0;
                    end
                end
                ST_SETUP: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_empty) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_fill_color <= r_color;
                        r_state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end else if (!cpu_we_i) begin
                        vmem_we_o    <= 1'b1;
                        vmem_waddr_o <= {w_cy, w_cx};
                        vmem_wdata_o <= r_fill_color;
                        r_pixcnt     <= r_pixcnt + 17'd1;
                        if (w_scan_last) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vmem_fill_engine.sv
// Randomized bench for vmem_fill_engine against a rectangle/raster reference model.
module tb_vmem_fill_engine;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        reg_we_i = 1'b0;
    logic [4:0]  reg_addr_i = '0;
    logic [31:0] reg_wdata_i = '0;
    logic [31:0] reg_rdata_o;
    logic        cpu_we_i = 1'b0;
    logic [15:0] cpu_waddr_i = '0;
    logic [2:0]  cpu_wdata_i = '0;
    logic        vmem_we_o;
    logic [15:0] vmem_waddr_o;
    logic [2:0]  vmem_wdata_o;
    logic        busy_o;

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  data;
        int          cyc;
    } wr_t;

    wr_t wq[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_err = 0;

    vmem_fill_engine dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .reg_we_i     (reg_we_i),
        .reg_addr_i   (reg_addr_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg_rdata_o  (reg_rdata_o),
        .cpu_we_i     (cpu_we_i),
        .cpu_waddr_i  (cpu_waddr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .vmem_we_o    (vmem_we_o),
        .vmem_waddr_o (vmem_waddr_o),
        .vmem_wdata_o (vmem_wdata_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) if (vmem_we_o) wq.push_back('{vmem_waddr_o, vmem_wdata_o, cyc});

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic reg_write(input int idx, input logic [31:0] data);
        reg_we_i    = 1'b1;
        reg_addr_i  = 5'(idx << 2);
        reg_wdata_i = data;
        tick();
        reg_we_i    = 1'b0;
    endtask

    task automatic reg_read(input int idx, output logic [31:0] data);
        reg_addr_i = 5'(idx << 2);
        tick();
        data = reg_rdata_o;
    endtask

    // Returns the edge at which busy_o was first seen low, or -1 on timeout.
    task automatic wait_idle(output int t_end);
        t_end = -1;
        for (int i = 0; i < 70000; i++) begin
            tick();
            if (!busy_o) begin
                t_end = cyc;
                break;
            end
        end
    endtask

    // Index of the first write not matching the raster of the box, -1 if all match.
    function automatic int first_bad(input wr_t fw[$], input int x0, input int y0,
                                     input int xe, input int ye, input int color);
        int idx;
        idx = 0;
        for (int y = y0; y < ye; y++)
            for (int x = x0; x < xe; x++) begin
                if (idx >= fw.size()) return idx;
                if (int'(fw[idx].addr) != ((y << 8) | x) || int'(fw[idx].data) != (color & 7))
                    return idx;
                idx++;
            end
        return -1;
    endfunction

    task automatic run_fill(input int x0, input int y0, input int w, input int h,
                            input int color, input string name);
        int xe, ye, n, t, t_end;
        logic [31:0] rd;
        xe = (x0 + w > 240) ? 240 : x0 + w;
        ye = (y0 + h > 240) ? 240 : y0 + h;
        n  = (w == 0 || h == 0 || x0 >= 240 || y0 >= 240) ? 0 : (xe - x0) * (ye - y0);
        reg_write(1, 32'((y0 << 8) | x0));
        reg_write(2, 32'((h << 16) | w));
        reg_write(3, 32'(color));
        wq.delete();
        reg_write(0, 32'h1);
        t = cyc;
        wait_idle(t_end);
        check_val({name, ":busy_end"}, 32'(t_end), 32'(t + 1 + n));
        tick();
        tick();
        check_val({name, ":count"}, 32'(wq.size()), 32'(n));
        check_val({name, ":raster"}, 32'(first_bad(wq, x0, y0, xe, ye, color)), 32'hFFFF_FFFF);
        if (n > 0 && wq.size() > 0) begin
            check_val({name, ":first_cyc"}, 32'(wq[0].cyc), 32'(t + 2));
            check_val({name, ":last_cyc"}, 32'(wq[wq.size()-1].cyc), 32'(t + 1 + n));
        end
        reg_read(0, rd);
        check_val({name, ":ctrl"}, rd, 32'h2);
        reg_read(4, rd);
        check_val({name, ":pixcnt"}, rd, 32'(n));
    endtask

    initial begin
        logic [31:0] rd, sz;
        int t, t_end, x0, y0, col, ncpu, rst_edge, late;
        wr_t fw[$];

        tick(); tick(); tick();
        rst_i = 1'b0;
        check_val("rst:vmem_we", 32'(vmem_we_o), 32'h0);
        check_val("rst:vmem_addr", 32'(vmem_waddr_o), 32'h0);
        check_val("rst:vmem_data", 32'(vmem_wdata_o), 32'h0);
        check_val("rst:busy", 32'(busy_o), 32'h0);
        for (int i = 0; i < 5; i++) begin
            reg_read(i, rd);
            check_val($sformatf("rst:reg%0d", i), rd, 32'h0);
        end

        reg_write(1, 32'h0000_0A05);
        reg_read(1, rd);
        check_val("rb:origin", rd, 32'h0000_0A05);
        sz = $urandom;
        reg_write(2, sz);
        reg_read(2, rd);
        check_val("rb:size", rd, {7'b0, sz[24:16], 7'b0, sz[8:0]});
        reg_write(6, 32'hFFFF_FFFF);
        reg_read(6, rd);
        check_val("rb:unmapped", rd, 32'h0);

        reg_write(0, 32'h3);
        tick();
        check_val("abort_and_start:busy", 32'(busy_o), 32'h0);

        run_fill(0, 0, 240, 240, 5, "clear");
        run_fill(230, 235, 20, 20, 3, "clip");
        run_fill(10, 10, 0, 5, 1, "deg_w0");
        run_fill(240, 3, 5, 5, 1, "deg_x240");
        for (int k = 0; k < 8; k++)
            run_fill($urandom_range(0, 250), $urandom_range(0, 250), $urandom_range(0, 40),
                     $urandom_range(0, 20), $urandom_range(0, 7), $sformatf("rnd%0d", k));

        // CPU contention during a 4x4 fill; box rows >= 100 never hit 0x1234
        x0 = $urandom_range(0, 200);
        y0 = $urandom_range(100, 200);
        col = $urandom_range(0, 7);
        reg_write(1, 32'((y0 << 8) | x0));
        reg_write(2, 32'((4 << 16) | 4));
        reg_write(3, 32'(col));
        wq.delete();
        reg_write(0, 32'h1);
        t = cyc;
        tick(); tick(); tick();
        cpu_we_i = 1'b1; cpu_waddr_i = 16'h1234; cpu_wdata_i = 3'd2;
        tick(); tick(); tick();
        cpu_we_i = 1'b0;
        wait_idle(t_end);
        check_val("cpu:busy_end", 32'(t_end), 32'(t + 20));
        tick(); tick();
        ncpu = 0;
        fw.delete();
        foreach (wq[i]) begin
            if (wq[i].cyc >= t + 4 && wq[i].cyc <= t + 6) begin
                if (wq[i].addr == 16'h1234 && wq[i].data == 3'd2) ncpu++;
            end else begin
                fw.push_back(wq[i]);
            end
        end
        check_val("cpu:cpu_writes", 32'(ncpu), 32'd3);
        check_val("cpu:fill_count", 32'(fw.size()), 32'd16);
        check_val("cpu:raster", 32'(first_bad(fw, x0, y0, x0 + 4, y0 + 4, col)), 32'hFFFF_FFFF);

        // Abort a full-screen fill after ~100 writes
        reg_write(1, 32'h0);
        reg_write(2, 32'((240 << 16) | 240));
        wq.delete();
        reg_write(0, 32'h1);
        for (int i = 0; i < 1000 && wq.size() < 100; i++) tick();
        reg_write(0, 32'h2);
        tick(); tick(); tick();
        check_val("abort:le101", 32'(wq.size() <= 101 && wq.size() >= 100), 32'h1);
        check_val("abort:busy", 32'(busy_o), 32'h0);
        reg_read(0, rd);
        check_val("abort:ctrl", rd, 32'h0);
        reg_read(4, rd);
        check_val("abort:pixcnt", rd, 32'(wq.size()));
        run_fill($urandom_range(0, 200), $urandom_range(0, 200), $urandom_range(1, 10),
                 $urandom_range(1, 10), $urandom_range(0, 7), "restart");

        // Synchronous reset in the middle of a fill
        reg_write(2, 32'((240 << 16) | 240));
        reg_write(0, 32'h1);
        for (int i = 0; i < 50; i++) tick();
        rst_i = 1'b1;
        tick();
        rst_edge = cyc;
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        late = 0;
        foreach (wq[i]) if (wq[i].cyc >= rst_edge) late++;
        check_val("midrst:late_writes", 32'(late), 32'h0);
        check_val("midrst:busy", 32'(busy_o), 32'h0);
        check_val("midrst:vmem_addr", 32'(vmem_waddr_o), 32'h0);
        for (int i = 0; i < 5; i++) begin
            reg_read(i, rd);
            check_val($sformatf("midrst:reg%0d", i), rd, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
